updown_mod_counter: RTL and testbench

//  Parametrised synchronous up/down counter with programmable modulus, parallel

---
 rtl/updown_mod_counter.sv | 77 +++++++
 tb/tb_updown_mod_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Parametrised up/down counter with programmable modulus, parallel load,
// wrap/saturate mode, Gray-coded view of the count and terminal-count flags.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 2**WIDTH,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             u,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    // Reject parameter sets that leave no usable count range.
    if (WIDTH < 1 || MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_params
        $error("updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
    end

    logic             at_max;
    logic             at_zero;
    logic             above_max;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign at_max    = (q == MAX_VAL);
    assign at_zero   = (q == '0);
    assign above_max = (q > MAX_VAL);

    // Terminal count looks one edge ahead so it can cascade into a next stage's en.
    assign tc   = en & ~load & (u ? at_max : at_zero);
    assign gray = q ^ (q >> 1);

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (din > MAX_VAL) ? MAX_VAL : din;
        end else if (en) begin
            if (u) begin
                if (at_max) begin
                    q_next    = SATURATE ? q : '0;
                    wrap_next = ~SATURATE;
                end else if (above_max) begin
                    q_next = '0;
                end else begin
                    q_next = q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    q_next    = SATURATE ? '0 : MAX_VAL;
                    wrap_next = ~SATURATE;
                end else begin
                    q_next = q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: four configurations share one stimulus stream,
// each checked every cycle against an arithmetic model plus literal expectations.
module tb_updown_mod_counter;

    localparam int N = 4;
    localparam int WS[N]   = '{3, 4, 4, 3};
    localparam int MODS[N] = '{8, 10, 16, 7};
    localparam int SATS[N] = '{0, 0, 1, 0};

    logic       clk;
    logic       clear;
    logic       en;
    logic       u;
    logic       load;
    logic [3:0] din;

    logic [2:0] q0, g0;
    logic [3:0] q1, g1, q2, g2;
    logic [2:0] q3, g3;
    logic       tc0, tc1, tc2, tc3;
    logic       wr0, wr1, wr2, wr3;

    int  checks = 0;
    int  errors = 0;
    bit  run    = 1'b0;
    int  mq[N];
    bit  mw[N];

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_c0 (
        .clk(clk), .clear(clear), .en(en), .u(u), .load(load), .din(din[2:0]),
        .q(q0), .gray(g0), .tc(tc0), .wrap(wr0));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
        .clk(clk), .clear(clear), .en(en), .u(u), .load(load), .din(din),
        .q(q1), .gray(g1), .tc(tc1), .wrap(wr1));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_c2 (
        .clk(clk), .clear(clear), .en(en), .u(u), .load(load), .din(din),
        .q(q2), .gray(g2), .tc(tc2), .wrap(wr2));
    updown_mod_counter #(.WIDTH(3), .MODULUS(7), .SATURATE(1'b0)) u_c3 (
        .clk(clk), .clear(clear), .en(en), .u(u), .load(load), .din(din[2:0]),
        .q(q3), .gray(g3), .tc(tc3), .wrap(wr3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: count range 0..M-1, stepping with modular or clamped arithmetic.
    always @(posedge clk or negedge clear) begin
        for (int k = 0; k < N; k++) begin
            int m;
            int d;
            m = MODS[k];
            d = int'(din) % (1 << WS[k]);
            if (!clear) begin
                mq[k] = 0;
                mw[k] = 1'b0;
            end else if (load) begin
                mq[k] = (d < m - 1) ? d : m - 1;
                mw[k] = 1'b0;
            end else if (en && u) begin
                mw[k] = (SATS[k] == 0) && (mq[k] == m - 1);
                if (mq[k] == m - 1) mq[k] = (SATS[k] != 0) ? mq[k] : 0;
                else                mq[k] = (mq[k] + 1) % m;
            end else if (en) begin
                mw[k] = (SATS[k] == 0) && (mq[k] == 0);
                if (mq[k] == 0) mq[k] = (SATS[k] != 0) ? 0 : m - 1;
                else            mq[k] = mq[k] - 1;
            end else begin
                mw[k] = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (run) begin
            int dq[N];
            int dg[N];
            int dt[N];
            int dw[N];
            dq = '{int'(q0), int'(q1), int'(q2), int'(q3)};
            dg = '{int'(g0), int'(g1), int'(g2), int'(g3)};
            dt = '{int'(tc0), int'(tc1), int'(tc2), int'(tc3)};
            dw = '{int'(wr0), int'(wr1), int'(wr2), int'(wr3)};
            for (int k = 0; k < N; k++) begin
                int etc;
                etc = (en && !load && (u ? (mq[k] == MODS[k] - 1) : (mq[k] == 0))) ? 1 : 0;
                chk($sformatf("c%0d q", k), dq[k], mq[k]);
                chk($sformatf("c%0d gray", k), dg[k], mq[k] ^ (mq[k] >> 1));
                chk($sformatf("c%0d tc", k), dt[k], etc);
                chk($sformatf("c%0d wrap", k), dw[k], int'(mw[k]));
            end
        end
    end

    task automatic drive(input bit e, input bit uu, input bit l, input logic [3:0] d);
        en   = e;
        u    = uu;
        load = l;
        din  = d;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd0);
        #1 clear = 1'b0;
        run = 1'b1;
        @(posedge clk);
        #2;
        chk("reset q0", int'(q0), 0);
        chk("reset wrap0", int'(wr0), 0);
        chk("reset gray0", int'(g0), 0);
        clear = 1'b1;

        // Up count, 3-bit full range and modulo-10
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        tick(7);
        chk("up q0 at 7", int'(q0), 7);
        chk("up tc0 at 7", int'(tc0), 1);
        chk("up gray0 at 7", int'(g0), 4);
        tick(1);
        chk("up q0 wrapped", int'(q0), 0);
        chk("up wrap0 pulse", int'(wr0), 1);
        tick(1);
        chk("up q0 after wrap", int'(q0), 1);
        chk("up wrap0 cleared", int'(wr0), 0);
        chk("mod10 q1 at 9", int'(q1), 9);
        chk("mod10 tc1 at 9", int'(tc1), 1);
        tick(1);
        chk("mod10 q1 wrapped", int'(q1), 0);
        chk("mod10 wrap1 pulse", int'(wr1), 1);

        // Down count from reset
        clear = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        #1;
        chk("clear q0", int'(q0), 0);
        chk("clear tc0 down", int'(tc0), 1);
        tick(1);
        clear = 1'b1;
        tick(1);
        chk("down q0 to 7", int'(q0), 7);
        chk("down wrap0", int'(wr0), 1);
        chk("down q1 to 9", int'(q1), 9);
        chk("down wrap1", int'(wr1), 1);
        tick(7);
        chk("down q0 at 0", int'(q0), 0);
        chk("down tc0 at 0", int'(tc0), 1);
        tick(1);
        chk("down q0 rewrap", int'(q0), 7);

        // Load clamps to MODULUS-1
        drive(1'b1, 1'b1, 1'b1, 4'd12);
        tick(1);
        chk("load q1 clamp", int'(q1), 9);
        chk("load q2", int'(q2), 12);
        chk("load q0 low bits", int'(q0), 4);
        chk("load wrap0", int'(wr0), 0);

        // Saturating instance
        drive(1'b1, 1'b1, 1'b1, 4'd14);
        tick(1);
        chk("sat load 14", int'(q2), 14);
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        tick(1);
        chk("sat q2 15", int'(q2), 15);
        tick(2);
        chk("sat q2 hold", int'(q2), 15);
        chk("sat wrap2", int'(wr2), 0);
        chk("sat tc2 up", int'(tc2), 1);
        drive(1'b1, 1'b0, 1'b1, 4'd0);
        tick(1);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        chk("sat q2 hold 0", int'(q2), 0);
        chk("sat tc2 down", int'(tc2), 1);
        chk("sat wrap2 down", int'(wr2), 0);

        // Load beats enable, then hold
        drive(1'b1, 1'b1, 1'b1, 4'd3);
        tick(1);
        chk("prio q2 at 3", int'(q2), 3);
        drive(1'b1, 1'b1, 1'b1, 4'd5);
        tick(1);
        chk("prio q2 load", int'(q2), 5);
        chk("prio q1 load", int'(q1), 5);
        drive(1'b0, 1'b1, 1'b0, 4'd0);
        tick(3);
        chk("hold q2", int'(q2), 5);
        chk("hold tc2", int'(tc2), 0);

        // Mid-cycle asynchronous clear with wrap high
        clear = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        tick(1);
        clear = 1'b1;
        tick(1);
        chk("mod7 q3 at 6", int'(q3), 6);
        chk("mod7 wrap3", int'(wr3), 1);
        #1 clear = 1'b0;
        #1;
        chk("async q3", int'(q3), 0);
        chk("async wrap3", int'(wr3), 0);
        clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        tick(1);
        chk("release q3", int'(q3), 1);
        chk("release q0", int'(q0), 1);
        tick(2);

        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
